// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, stats width
// and an elaboration-time clog2 helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int STATS_CNT_W = 16;

    // Ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle; master is the arbiter, slave is the
// environment (requesters plus FIFO).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;

    modport master (
        input  req, req_data, fifo_full,
        output ack, grant, busy, fifo_wr_en, fifo_data
    );

    modport slave (
        output req, req_data, fifo_full,
        input  ack, grant, busy, fifo_wr_en, fifo_data
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_owner, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    always_comb begin
        int         idx;
        logic [IDX_W-1:0] idx_w;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        // Walk from the farthest candidate back to the nearest so the
        // nearest requester after last_owner is the final assignment.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_owner) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IDX_W'(idx);
            if (req[idx_w]) begin
                winner = idx_w;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a FIFO write port. Optional per-requester
// beat counters are enabled by defining FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    fifo_wr_arbiter_if.master   bus
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_W-1:0] beat_cnt
`endif
);

    localparam int IDX_W   = clog2(NUM_REQ);
    localparam int BURST_W = clog2(MAX_BURST + 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
    logic [BURST_W-1:0] cnt_reg, cnt_next;

    logic [IDX_W-1:0]      pick_winner;
    logic                  pick_valid;
    logic                  busy;
    logic                  beat;
    logic [NUM_REQ-1:0]    ack_vec;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_reg),
        .winner     (pick_winner),
        .any_valid  (pick_valid)
    );

    assign busy = (state_reg == BUSY);
    assign beat = busy && bus.req[owner_reg] && !bus.fifo_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BUSY;
                    owner_next = pick_winner;
                end
            end
            BUSY: begin
                if (beat) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // A full FIFO only stalls; release needs a dropped request or the last beat.
                if (!bus.req[owner_reg] ||
                    (beat && cnt_reg == BURST_W'(MAX_BURST - 1))) begin
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                    cnt_next        = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign data_slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign grant_vec[gi]  = busy && (owner_reg == IDX_W'(gi));
        assign ack_vec[gi]    = beat && (owner_reg == IDX_W'(gi));
    end

    assign bus.ack        = ack_vec;
    assign bus.grant      = grant_vec;
    assign bus.busy       = busy;
    assign bus.fifo_wr_en = beat;
    assign bus.fifo_data  = busy ? data_slice[owner_reg] : '0;

`ifdef FIFO_WR_ARBITER_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [STATS_CNT_W-1:0] stat_reg;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                stat_reg <= '0;
            end else if (ack_vec[gi]) begin
                stat_reg <= stat_reg + 1'b1;
            end
        end
        assign beat_cnt[gi*STATS_CNT_W +: STATS_CNT_W] = stat_reg;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NR*16-1:0] beat_cnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester k presents 8'hA0 + 8'h11*k.
    task automatic drive_reset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = 32'hD3C2B1A0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.fifo_full = 1'b0;
        bus.req_data  = 32'hD3C2B1A0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en); end
        drive_reset();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [3:0] exp_g [7];
        exp_g = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        drive_reset();
        bus.req = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++; if (bus.grant !== exp_g[i]) begin n_fail++; $display("FAIL single_grant[%0d] got %b want %b", i, bus.grant, exp_g[i]); end
            n_checks++; if (bus.ack !== exp_g[i]) begin n_fail++; $display("FAIL single_ack[%0d] got %b want %b", i, bus.ack, exp_g[i]); end
            n_checks++; if (bus.fifo_wr_en !== (|exp_g[i])) begin n_fail++; $display("FAIL single_wr_en[%0d] got %b want %b", i, bus.fifo_wr_en, |exp_g[i]); end
            if (exp_g[i] != 4'b0000) begin
                n_checks++; if (bus.fifo_data !== 8'hA0) begin n_fail++; $display("FAIL single_data[%0d] got %h want a0", i, bus.fifo_data); end
            end
            @(posedge clk); #1;
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++; if (bus.ack !== 4'b0000 || bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_drop got ack %b grant %b want ack 0000 grant 0001", bus.ack, bus.grant); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_release got busy %b want 0", bus.busy); end
        $display("test_single done");
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        logic [7:0] exp_d;
        int owner;
        drive_reset();
        bus.req = 4'b1111;
        @(negedge clk);
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rot_first_idle got %b want 0000", bus.grant); end
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b <= MB; b++) begin
                @(posedge clk); #1;
                @(negedge clk);
                owner = g % NR;
                exp   = (b < MB) ? 4'(1 << owner) : 4'b0000;
                exp_d = 8'hA0 + 8'(owner * 8'h11);
                n_checks++; if (bus.grant !== exp) begin n_fail++; $display("FAIL rot_grant g%0d b%0d got %b want %b", g, b, bus.grant, exp); end
                n_checks++; if (bus.ack !== exp) begin n_fail++; $display("FAIL rot_ack g%0d b%0d got %b want %b", g, b, bus.ack, exp); end
                if (b < MB) begin
                    n_checks++; if (bus.fifo_data !== exp_d) begin n_fail++; $display("FAIL rot_data g%0d b%0d got %h want %h", g, b, bus.fifo_data, exp_d); end
                    $display("beat owner %0d data %h", owner, bus.fifo_data);
                end
            end
        end
        bus.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        $display("test_rotation done");
    endtask

    task automatic test_full_stall();
        logic       full_t [11];
        logic [3:0] exp_g  [11];
        logic [3:0] exp_a  [11];
        full_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_g  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        exp_a  = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
        drive_reset();
        for (int i = 0; i < 11; i++) begin
            bus.req       = (i < 10) ? 4'b0100 : 4'b0000;
            bus.fifo_full = full_t[i];
            @(negedge clk);
            n_checks++; if (bus.grant !== exp_g[i]) begin n_fail++; $display("FAIL stall_grant[%0d] got %b want %b", i, bus.grant, exp_g[i]); end
            n_checks++; if (bus.ack !== exp_a[i]) begin n_fail++; $display("FAIL stall_ack[%0d] got %b want %b", i, bus.ack, exp_a[i]); end
            n_checks++; if (bus.fifo_wr_en !== (|exp_a[i])) begin n_fail++; $display("FAIL stall_wr_en[%0d] got %b want %b", i, bus.fifo_wr_en, |exp_a[i]); end
            if (exp_g[i] != 4'h0) begin
                n_checks++; if (bus.fifo_data !== 8'hC2) begin n_fail++; $display("FAIL stall_data[%0d] got %h want c2", i, bus.fifo_data); end
            end
            @(posedge clk); #1;
        end
        bus.fifo_full = 1'b0;
        $display("test_full_stall done");
    endtask

    task automatic test_drop();
        logic [3:0] req_t [8];
        logic [3:0] exp_g [8];
        logic [3:0] exp_a [8];
        req_t = '{4'hA, 4'hA, 4'hA, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
        exp_g = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0};
        exp_a = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        drive_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req = req_t[i];
            @(negedge clk);
            n_checks++; if (bus.grant !== exp_g[i]) begin n_fail++; $display("FAIL drop_grant[%0d] got %b want %b", i, bus.grant, exp_g[i]); end
            n_checks++; if (bus.ack !== exp_a[i]) begin n_fail++; $display("FAIL drop_ack[%0d] got %b want %b", i, bus.ack, exp_a[i]); end
            @(posedge clk); #1;
        end
        $display("test_drop done");
    endtask

    task automatic test_reset_mid_burst();
        drive_reset();
        bus.req = 4'b0100;
        // First burst completes (last owner 2), second burst starts at cycle 6.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL mid_pre_ack got %b want 0100", bus.ack); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en got %b want 0", bus.fifo_wr_en); end
        n_checks++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL mid_ack got %b want 0000", bus.ack); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant got %b want 0000", bus.grant); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        bus.req = 4'b1111;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL mid_after_idle got %b want 0000", bus.grant); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL mid_priority got %b want 0001", bus.grant); end
        bus.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        $display("test_reset_mid_burst done");
    endtask

`ifdef FIFO_WR_ARBITER_STATS_EN
    task automatic test_stats();
        drive_reset();
        for (int i = 0; i < 16; i++) begin
            bus.req = (i < 13) ? 4'b1000 : 4'b0000;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (beat_cnt[48 +: 16] !== 16'd10) begin n_fail++; $display("FAIL stats_req3 got %0d want 10", beat_cnt[48 +: 16]); end
        n_checks++; if (beat_cnt[47:0] !== 48'd0) begin n_fail++; $display("FAIL stats_others got %h want 0", beat_cnt[47:0]); end
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_drop();
        test_reset_mid_burst();
`ifdef FIFO_WR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST beats.
- Drives the FIFO's wr_en/data_in and honours its full flag, so no write is attempted while full.
- Sits directly in front of the team FIFO; requesters see a req/ack handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 4, maximum beats per grant (>=1)
- Derived localparams (not overridable): IDX_W = clog2(NUM_REQ), BURST_W = clog2(MAX_BURST+1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  input  1  clock
- RST_N  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester write request; held high while the requester has data
- req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ack  output  NUM_REQ  one-hot; high in a cycle where that requester's beat is written
- grant  output  NUM_REQ  one-hot current owner; all zero when idle
- busy  output  1  high in BUSY state
- fifo_full  input  1  FIFO full flag
- fifo_wr_en  output  1  FIFO write enable
- fifo_data  output  DATA_WIDTH  FIFO write data

Behaviour:
- Reset values:
  - state=IDLE; grant=0; busy=0; ack=0; fifo_wr_en=0.
  - Beat counter=0; last-owner pointer=NUM_REQ-1, so requester 0 wins first.
- Reset assertion mid-burst clears all state immediately. fifo_wr_en and ack drop in the same cycle because they are combinational from state.
- FSM IDLE -> BUSY:
  - In IDLE with req!=0, pick the first requester with req=1 searching from last_owner+1 upward, wrapping modulo NUM_REQ.
  - Register the winner as owner and enter BUSY at the next edge. Arbitration latency is 1 cycle.
- Beat rule in BUSY:
  - beat = req[owner] & ~fifo_full.
  - fifo_wr_en = beat; ack[owner] = beat.
  - fifo_data = req_data slice of owner, driven whenever BUSY, regardless of beat.
  - Each beat increments the counter.
- FSM BUSY -> IDLE, at the next edge, when either:
  - req[owner]=0, or
  - a beat occurs with counter==MAX_BURST-1.
- On release: last_owner <= owner, counter <= 0, grant <= 0.
- There is one bubble cycle (IDLE) between grants. This is required behaviour.
- fifo_full high in BUSY stalls the owner: no beat, counter unchanged, grant held indefinitely until full clears or req drops.
- Requests from non-owners are ignored until the next IDLE arbitration. Their ack stays 0.
- A requester may drop req at any cycle. If it drops in the cycle it would have been acked, no beat occurs.
- Fairness:
  - With all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
  - Each grant carries exactly MAX_BURST beats when the FIFO is not full.
- fifo_wr_en is never high while fifo_full is high.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STATS_EN.
- Defined:
  - Adds output beat_cnt (NUM_REQ*16 bits).
  - One 16-bit wrapping counter per requester, incremented on each of its acks.
  - Counters reset to 0 on RST_N and wrap from 0xFFFF to 0x0000.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - clog2 helper function
  - STATS_CNT_W=16
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_owner index.
  - Outputs: winner index, any_valid.
  - Reusable by other arbiters.

Test Plan:
- Reset then req=4'b0001, fifo_full=0 -> grant=0001 one cycle later; 4 acks on consecutive cycles; IDLE bubble; re-grant to 0 next.
- req=4'b1111 held, MAX_BURST=4 -> owner sequence 0,1,2,3,0 with 4 beats each; fifo_data matches each owner's slice on every beat.
- Owner 2 mid-burst with fifo_full=1 for 5 cycles -> fifo_wr_en=0 and ack=0 for those 5 cycles, grant held at 0100, burst resumes with remaining beats.
- Owner 1 drops req after 2 beats while req[3]=1 -> IDLE at next edge, then grant=1000.
- Assert RST_N low mid-burst -> fifo_wr_en, ack, grant, busy all 0 in the same cycle; after release, requester 0 has first priority.
- With FIFO_WR_ARBITER_STATS_EN defined: 10 beats from requester 3 -> beat_cnt slice 3 equals 10, other slices 0.
